mult_job_scheduler: RTL and testbench

- Shares one configurable_multiplication instance between two requesters (e.g. SoC register slave and a DMA/stream engine).
- Accepts jobs over valid/ready, arbitrates round-robin, and sequences the multiplier's reset/enable/mode pins.
- Captures the product on data_valid and returns it to the winning requester over valid/ready.
- Adds a timeout watchdog and illegal-mode rejection so a requester is never left hanging.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/mult_job_scheduler.sv | 136 +++++++++++++
 tb/tb_mult_job_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier job scheduler.
//   - cm codes understood by the shared configurable multiplier
//   - scheduler FSM state encoding
//   - default watchdog length
package mult_pkg;

  localparam logic [1:0] CM_SINGLE8  = 2'b00;
  localparam logic [1:0] CM_PAR8     = 2'b01;
  localparam logic [1:0] CM_SINGLE16 = 2'b10;
  localparam logic [1:0] CM_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector (bit n = requester n)
//   update     : strobe, requester upd_id has just been served
//   upd_id     : id of the served requester
//   grant      : one-hot grant (combinational)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_id,
  output logic [1:0] grant
);

  // prio = requester favoured on a tie, i.e. the one not served last.
  logic prio;
  logic prio_eff;

  always_ff @(posedge clk) begin
    if (!rst_n)      prio <= 1'b0;
    else if (update) prio <= ~upd_id;
  end

  // While the update strobe is up the grant already reflects the new
  // pointer, so a registered ready computed this cycle is fair next cycle.
  assign prio_eff = update ? ~upd_id : prio;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_eff ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mult_job_scheduler.sv
// Shares one configurable multiplier between two requesters.
//   req_*  : job channel per requester (valid/ready, operands, cm mode)
//   rsp_*  : response channel per requester (valid/ready), shared product/error
//   busy_o : FSM not in IDLE
//   mul_*  : pins of the shared multiplier (reset, enable, mode, operands,
//            product, data_valid)
module mult_job_scheduler
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_operands_i,
  input  logic [3:0]  req_mode_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_product_o,
  output logic        rsp_error_o,
  output logic        busy_o,
  output logic        mul_reset_no,
  output logic        mul_enable_o,
  output logic [1:0]  mul_cm_o,
  output logic [15:0] mul_multiplicand_o,
  output logic [15:0] mul_multiplier_o,
  input  logic [31:0] mul_product_i,
  input  logic        mul_data_valid_i
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             id;
  logic [1:0]       hs, grant;
  logic             hs_id, rsp_done;
  logic [31:0]      sel_ops;
  logic [1:0]       sel_mode;

  // ready is one-hot, so at most one handshake bit is set
  assign hs       = req_valid_i & req_ready_o;
  assign hs_id    = hs[1];
  assign sel_ops  = hs_id ? req_operands_i[63:32] : req_operands_i[31:0];
  assign sel_mode = hs_id ? req_mode_i[3:2]       : req_mode_i[1:0];
  assign rsp_done = (state == S_RESP) && rsp_ready_i[id];

  rr_arbiter2 u_arb (
    .clk    (clk_i),
    .rst_n  (reset_ni),
    .req    (req_valid_i),
    .update (rsp_done),
    .upd_id (id),
    .grant  (grant)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state              <= S_IDLE;
      cnt                <= '0;
      id                 <= 1'b0;
      req_ready_o        <= 2'b00;
      rsp_valid_o        <= 2'b00;
      rsp_product_o      <= '0;
      rsp_error_o        <= 1'b0;
      busy_o             <= 1'b0;
      mul_reset_no       <= 1'b0;
      mul_enable_o       <= 1'b0;
      mul_cm_o           <= 2'b00;
      mul_multiplicand_o <= '0;
      mul_multiplier_o   <= '0;
    end else begin
      mul_enable_o <= 1'b0;
      case (state)
        S_IDLE: begin
          mul_reset_no <= 1'b1;
          req_ready_o  <= grant;
          if (hs != 2'b00) begin
            req_ready_o <= 2'b00;
            id          <= hs_id;
            busy_o      <= 1'b1;
            if (sel_mode == CM_ILLEGAL) begin
              // reject without touching the multiplier
              rsp_valid_o   <= hs_id ? 2'b10 : 2'b01;
              rsp_product_o <= '0;
              rsp_error_o   <= 1'b1;
              state         <= S_RESP;
            end else begin
              // multiplier reset low for the CLEAR cycle flushes stale data_valid
              mul_reset_no       <= 1'b0;
              mul_cm_o           <= sel_mode;
              mul_multiplicand_o <= sel_ops[31:16];
              mul_multiplier_o   <= sel_ops[15:0];
              state              <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          mul_reset_no <= 1'b1;
          mul_enable_o <= 1'b1;
          state        <= S_START;
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // data_valid is tested first so it wins over a coincident timeout
          if (mul_data_valid_i) begin
            rsp_product_o <= mul_product_i;
            rsp_error_o   <= 1'b0;
            rsp_valid_o   <= id ? 2'b10 : 2'b01;
            state         <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_product_o <= '0;
            rsp_error_o   <= 1'b1;
            rsp_valid_o   <= id ? 2'b10 : 2'b01;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready_i[id]) begin
            rsp_valid_o <= 2'b00;
            busy_o      <= 1'b0;
            req_ready_o <= grant;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Directed bench for mult_job_scheduler with a small multiplier model
// (data_valid three cycles after the enable pulse, optional hang).
module tb_mult_job_scheduler;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [63:0] req_operands_i;
  logic [3:0]  req_mode_i;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [31:0] rsp_product_o;
  logic        rsp_error_o;
  logic        busy_o;
  logic        mul_reset_no;
  logic        mul_enable_o;
  logic [1:0]  mul_cm_o;
  logic [15:0] mul_multiplicand_o;
  logic [15:0] mul_multiplier_o;
  logic [31:0] mul_product_i = '0;
  logic        mul_data_valid_i = 1'b0;

  always #5 clk = ~clk;

  mult_job_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i              (clk),
    .reset_ni           (reset_ni),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_operands_i     (req_operands_i),
    .req_mode_i         (req_mode_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_product_o      (rsp_product_o),
    .rsp_error_o        (rsp_error_o),
    .busy_o             (busy_o),
    .mul_reset_no       (mul_reset_no),
    .mul_enable_o       (mul_enable_o),
    .mul_cm_o           (mul_cm_o),
    .mul_multiplicand_o (mul_multiplicand_o),
    .mul_multiplier_o   (mul_multiplier_o),
    .mul_product_i      (mul_product_i),
    .mul_data_valid_i   (mul_data_valid_i)
  );

  // ---------------- multiplier model ----------------
  logic        hang = 1'b0;
  logic        pend = 1'b0;
  logic [1:0]  dly  = '0;
  logic [31:0] pprod = '0;
  logic [1:0]  last_cm = '0;
  int          en_cnt = 0;

  function automatic logic [31:0] model_mul(input logic [1:0] cm,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic [15:0]        lo, hi;
    logic signed [31:0] sa, sb, sp;
    lo = {8'h00, a[7:0]}  * {8'h00, b[7:0]};
    hi = {8'h00, a[15:8]} * {8'h00, b[15:8]};
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    sp = sa * sb;
    case (cm)
      2'b00:   return {16'h0000, lo};
      2'b01:   return {hi, lo};
      default: return sp;
    endcase
  endfunction

  always @(posedge clk) begin
    mul_data_valid_i <= 1'b0;
    if (!mul_reset_no) begin
      pend <= 1'b0;
    end else if (mul_enable_o) begin
      pend    <= !hang;
      dly     <= 2'd1;
      pprod   <= model_mul(mul_cm_o, mul_multiplicand_o, mul_multiplier_o);
      en_cnt  <= en_cnt + 1;
      last_cm <= mul_cm_o;
    end else if (pend) begin
      if (dly == 2'd0) begin
        mul_data_valid_i <= 1'b1;
        mul_product_i    <= pprod;
        pend             <= 1'b0;
      end else begin
        dly <= dly - 2'd1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    while (rsp_valid_o == 2'b00 && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // returns at the negedge right after the accept edge
  task automatic wait_accept(output logic [1:0] acc);
    acc = 2'b00;
    for (int i = 0; i < 40; i++) begin
      if ((req_valid_i & req_ready_o) != 2'b00) begin
        acc = req_valid_i & req_ready_o;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic ack();
    rsp_ready_i = rsp_valid_o;
    @(negedge clk);
    rsp_ready_i = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int         cyc;
  logic [1:0] acc;
  int         base;
  logic       stable, seen;

  initial begin
    // ---- 1: reset with both requesters valid ----
    reset_ni       = 1'b0;
    req_valid_i    = 2'b11;
    req_operands_i = {32'h0010_0011, 32'hF2BA_1BF7};   // req0 = {-3398, 7159}
    req_mode_i     = 4'b00_10;
    rsp_ready_i    = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",   req_ready_o, 32'd0);
    chk("rst_mul_reset_n", mul_reset_no, 32'd0);
    chk("rst_rsp_busy",    {rsp_valid_o, rsp_error_o, busy_o}, 32'd0);
    chk("rst_mul_ctl",     {mul_enable_o, mul_cm_o}, 32'd0);
    chk("rst_ops",         {mul_multiplicand_o, mul_multiplier_o}, 32'd0);
    chk("rst_product",     rsp_product_o, 32'd0);
    reset_ni = 1'b1;
    @(negedge clk);
    chk("first_grant",      req_ready_o, 32'h1);
    chk("idle_mul_reset_n", mul_reset_no, 32'h1);

    // ---- 2: req0 single 16-bit job ----
    req_valid_i = 2'b01;
    @(negedge clk);                       // CLEAR
    req_valid_i = 2'b00;
    chk("t2_clear", {busy_o, mul_reset_no, mul_enable_o, mul_cm_o}, 32'b10010);
    chk("t2_ops",   {mul_multiplicand_o, mul_multiplier_o}, 32'hF2BA_1BF7);
    @(negedge clk);                       // START
    chk("t2_enable_pulse", {mul_enable_o, mul_reset_no}, 32'b11);
    @(negedge clk);                       // first WAIT cycle
    chk("t2_enable_drop", mul_enable_o, 32'd0);
    wait_rsp(20, cyc);
    chk("t2_latency",   cyc, 32'd3);
    chk("t2_rsp_valid", rsp_valid_o, 32'h1);
    chk("t2_product",   rsp_product_o, 32'hFE8C_CF76);
    chk("t2_error",     rsp_error_o, 32'd0);
    chk("t2_enables",   en_cnt, 32'd1);
    chk("t2_cm_seen",   last_cm, 32'h2);
    ack();
    chk("t2_idle", {busy_o, rsp_valid_o}, 32'd0);

    // ---- 4: illegal mode from req1 ----
    req_operands_i[63:32] = 32'h1234_5678;
    req_mode_i  = 4'b11_10;
    req_valid_i = 2'b10;
    base = en_cnt;
    wait_accept(acc);
    req_valid_i = 2'b00;
    chk("t4_accept", acc, 32'h2);
    wait_rsp(2, cyc);
    chk("t4_latency",   cyc, 32'd0);
    chk("t4_rsp_valid", rsp_valid_o, 32'h2);
    chk("t4_error",     rsp_error_o, 32'h1);
    chk("t4_product",   rsp_product_o, 32'd0);
    chk("t4_no_enable", en_cnt, base);
    chk("t4_mul_untouched", {mul_reset_no, mul_cm_o}, 32'b110);
    ack();

    // ---- 3: both valid, alternating grants ----
    req_operands_i = {32'h0010_0011, 32'h0203_0405};
    req_mode_i     = 4'b00_01;
    req_valid_i    = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(40, cyc);
      chk($sformatf("t3_grant%0d", k),   rsp_valid_o,   (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t3_product%0d", k), rsp_product_o, (k % 2 == 0) ? 32'h0008_000F : 32'h0000_0110);
      rsp_ready_i = rsp_valid_o;
      @(negedge clk);
      rsp_ready_i = 2'b00;
      if (k == 3) req_valid_i = 2'b00;
    end

    // ---- 5: multiplier hangs -> timeout ----
    hang = 1'b1;
    req_operands_i[31:0] = 32'h0003_0005;
    req_mode_i  = 4'b00_10;
    req_valid_i = 2'b01;
    wait_accept(acc);
    req_valid_i = 2'b00;
    chk("t5_accept", acc, 32'h1);
    wait_rsp(40, cyc);
    chk("t5_timeout_cycles", cyc, 32'd10);
    chk("t5_rsp_valid", rsp_valid_o, 32'h1);
    chk("t5_error",     rsp_error_o, 32'h1);
    chk("t5_product",   rsp_product_o, 32'd0);
    ack();
    hang = 1'b0;
    req_operands_i[63:32] = 32'h0064_FFFE;              // 100 * -2
    req_mode_i  = 4'b10_10;
    req_valid_i = 2'b10;
    wait_accept(acc);
    req_valid_i = 2'b00;
    wait_rsp(20, cyc);
    chk("t5_next_valid",   rsp_valid_o, 32'h2);
    chk("t5_next_product", rsp_product_o, 32'hFFFF_FF38);
    chk("t5_next_error",   rsp_error_o, 32'd0);
    ack();

    // ---- 6: held response, then reset mid-WAIT ----
    req_valid_i = 2'b01;
    wait_accept(acc);
    req_valid_i = 2'b00;
    wait_rsp(20, cyc);
    chk("t6_rsp_valid", rsp_valid_o, 32'h1);
    rsp_ready_i = 2'b10;                  // ready from the other requester only
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 2'b01 || rsp_product_o !== 32'h0000_000F || rsp_error_o !== 1'b0)
        stable = 1'b0;
    end
    chk("t6_held_stable", stable, 32'h1);
    rsp_ready_i = 2'b01;
    @(negedge clk);
    rsp_ready_i = 2'b00;
    chk("t6_released", rsp_valid_o, 32'd0);

    req_valid_i = 2'b10;
    wait_accept(acc);                     // CLEAR
    req_valid_i = 2'b00;
    repeat (3) @(negedge clk);            // START, WAIT, WAIT
    chk("t6_in_wait", busy_o, 32'h1);
    reset_ni = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    chk("t6_reset_state", {busy_o, rsp_valid_o, mul_reset_no}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o != 2'b00 || busy_o) seen = 1'b1;
    end
    chk("t6_no_rsp_after_reset", seen, 32'd0);
    chk("t6_idle_after", {busy_o, mul_reset_no}, 32'b01);
    req_valid_i = 2'b11;
    @(negedge clk);
    chk("t6_ptr_reset", req_ready_o, 32'h1);
    req_valid_i = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
